// File: rtl/rat_irq_ctrl.sv
// Multi-source interrupt controller for the RAT CPU: up to 8 maskable sources,
// per-source edge/level mode, fixed lowest-index priority, port-mapped registers.
module rat_irq_ctrl #(
  parameter int          NUM_SRC    = 8,
  parameter logic [7:0]  BASE_PORT  = 8'hF0,
  parameter logic [9:0]  VEC_BASE   = 10'h3E0,
  parameter int          VEC_STRIDE = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_SRC-1:0] src,
  input  logic [7:0]         port_id,
  input  logic [7:0]         out_port,
  input  logic               io_strb,
  output logic [7:0]         rd_data,
  output logic               irq,
  input  logic               irq_ack,
  input  logic               irq_done,
  output logic [9:0]         vector,
  output logic [2:0]         irq_id
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ASSERT  = 2'd1,
    SERVICE = 2'd2
  } state_t;

  localparam logic [7:0] PORT_MASK = BASE_PORT;
  localparam logic [7:0] PORT_MODE = BASE_PORT + 8'd1;
  localparam logic [7:0] PORT_PEND = BASE_PORT + 8'd2;
  localparam logic [7:0] PORT_STAT = BASE_PORT + 8'd3;
  localparam logic [9:0] STRIDE10  = 10'(VEC_STRIDE);

  state_t             state;
  logic [NUM_SRC-1:0] s1, s2, s3;
  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] mask, mode, pend;
  logic [NUM_SRC-1:0] pend_next;
  logic [NUM_SRC-1:0] req;
  logic [7:0]         req8, mode8, mask8, pend8;
  logic [7:0]         ack_onehot;
  logic [2:0]         win_id;
  logic [9:0]         win_vec;
  logic               wr_mask, wr_mode, wr_pend;
  logic               ack_take;

  // Three-flop chain: s1/s2 resolve metastability, s3 gives the edge reference.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
    end else begin
      s1 <= src;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise     = s2 & ~s3;
  assign wr_mask  = io_strb && (port_id == PORT_MASK);
  assign wr_mode  = io_strb && (port_id == PORT_MODE);
  assign wr_pend  = io_strb && (port_id == PORT_PEND);
  assign ack_take = irq_ack && (state == ASSERT);

  assign mask8      = 8'(mask);
  assign mode8      = 8'(mode);
  assign pend8      = 8'(pend);
  assign ack_onehot = 8'b1 << irq_id;

  // Clears are applied first so a same-cycle captured rise always survives.
  always_comb begin
    pend_next = pend;
    if (wr_pend)
      pend_next = pend_next & ~out_port[NUM_SRC-1:0];
    if (ack_take && mode8[irq_id])
      pend_next = pend_next & ~ack_onehot[NUM_SRC-1:0];
    pend_next = pend_next | (rise & mode);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask <= '0;
      mode <= '0;
      pend <= '0;
    end else begin
      if (wr_mask)
        mask <= out_port[NUM_SRC-1:0];
      if (wr_mode)
        mode <= out_port[NUM_SRC-1:0];
      pend <= pend_next;
    end
  end

  assign req  = mask & ((mode & pend) | (~mode & s2));
  assign req8 = 8'(req);

  always_comb begin
    win_id = 3'd0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (req[i])
        win_id = 3'(i);
    end
  end

  assign win_vec = VEC_BASE + (10'(win_id) * STRIDE10);

  // Winner is latched only in IDLE, so a pending request cannot be preempted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      irq    <= 1'b0;
      irq_id <= 3'd0;
      vector <= VEC_BASE;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            irq_id <= win_id;
            vector <= win_vec;
            irq    <= 1'b1;
            state  <= ASSERT;
          end
        end
        ASSERT: begin
          if (irq_ack) begin
            irq   <= 1'b0;
            state <= SERVICE;
          end else if (!req8[irq_id]) begin
            irq   <= 1'b0;
            state <= IDLE;
          end
        end
        SERVICE: begin
          irq <= 1'b0;
          if (irq_done)
            state <= IDLE;
        end
        default: begin
          irq   <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  always_comb begin
    rd_data = 8'h00;
    case (port_id)
      PORT_MASK: rd_data = mask8;
      PORT_MODE: rd_data = mode8;
      PORT_PEND: rd_data = pend8;
      PORT_STAT: rd_data = {state, 2'b00, 1'b0, irq_id};
      default:   rd_data = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_rat_irq_ctrl.sv
// Directed bench for rat_irq_ctrl: register access table followed by
// hand-timed sequences for latency, priority, withdrawal, W1C race and reset.
module tb_rat_irq_ctrl;

  logic       clk;
  logic       reset_n;
  logic [7:0] src;
  logic [7:0] port_id;
  logic [7:0] out_port;
  logic       io_strb;
  logic [7:0] rd_data;
  logic       irq;
  logic       irq_ack;
  logic       irq_done;
  logic [9:0] vector;
  logic [2:0] irq_id;

  int total;
  int bad;

  typedef struct {
    logic       wr;
    logic [7:0] port;
    logic [7:0] data;
    logic [7:0] exp_rd;
  } vec_t;

  vec_t vecs[9];

  rat_irq_ctrl #(
    .NUM_SRC(8),
    .BASE_PORT(8'hF0),
    .VEC_BASE(10'h3E0),
    .VEC_STRIDE(2)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .src(src),
    .port_id(port_id),
    .out_port(out_port),
    .io_strb(io_strb),
    .rd_data(rd_data),
    .irq(irq),
    .irq_ack(irq_ack),
    .irq_done(irq_done),
    .vector(vector),
    .irq_id(irq_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] port, input logic [7:0] data);
    port_id  = port;
    out_port = data;
    io_strb  = 1'b1;
    tick();
    io_strb  = 1'b0;
    out_port = 8'h00;
  endtask

  task automatic check_reg(input string name, input logic [7:0] port, input logic [7:0] expected);
    port_id = port;
    #1;
    checkOutput(name, 32'(rd_data), 32'(expected));
  endtask

  task automatic pulse_ack();
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
  endtask

  task automatic pulse_done();
    irq_done = 1'b1;
    tick();
    irq_done = 1'b0;
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    reset_n  = 1'b0;
    src      = 8'h00;
    port_id  = 8'h00;
    out_port = 8'h00;
    io_strb  = 1'b0;
    irq_ack  = 1'b0;
    irq_done = 1'b0;

    vecs[0] = '{1'b1, 8'hF0, 8'hA5, 8'hA5};
    vecs[1] = '{1'b1, 8'hF1, 8'h3C, 8'h3C};
    vecs[2] = '{1'b0, 8'hF0, 8'h00, 8'hA5};
    vecs[3] = '{1'b1, 8'hF2, 8'hFF, 8'h00};
    vecs[4] = '{1'b1, 8'hF3, 8'hFF, 8'h00};
    vecs[5] = '{1'b0, 8'hF4, 8'h00, 8'h00};
    vecs[6] = '{1'b0, 8'hEF, 8'h00, 8'h00};
    vecs[7] = '{1'b1, 8'hF1, 8'h00, 8'h00};
    vecs[8] = '{1'b1, 8'hF0, 8'h00, 8'h00};

    tick();
    tick();
    checkOutput("reset_irq", 32'(irq), 32'h0);
    checkOutput("reset_vector", 32'(vector), 32'h3E0);
    checkOutput("reset_irq_id", 32'(irq_id), 32'h0);
    reset_n = 1'b1;
    tick();
    check_reg("reset_stat", 8'hF3, 8'h00);

    // Stray ACK/DONE in IDLE must not move the FSM.
    pulse_ack();
    pulse_done();
    check_reg("stray_ack_stat", 8'hF3, 8'h00);

    for (int i = 0; i < 9; i++) begin
      if (vecs[i].wr)
        applyStimulus(vecs[i].port, vecs[i].data);
      check_reg($sformatf("table_%0d", i), vecs[i].port, vecs[i].exp_rd);
    end

    // Edge mode on source 3: IRQ on the fourth edge after the rise.
    applyStimulus(8'hF1, 8'h08);
    applyStimulus(8'hF0, 8'h08);
    src = 8'h08;
    tick();
    checkOutput("edge_lat_e1", 32'(irq), 32'h0);
    tick();
    src = 8'h00;
    checkOutput("edge_lat_e2", 32'(irq), 32'h0);
    tick();
    checkOutput("edge_lat_e3", 32'(irq), 32'h0);
    tick();
    checkOutput("edge_lat_e4", 32'(irq), 32'h1);
    checkOutput("edge_id", 32'(irq_id), 32'h3);
    checkOutput("edge_vector", 32'(vector), 32'h3E6);
    check_reg("edge_stat_assert", 8'hF3, 8'h43);
    pulse_ack();
    checkOutput("edge_ack_irq", 32'(irq), 32'h0);
    check_reg("edge_ack_pend", 8'hF2, 8'h00);
    check_reg("edge_stat_service", 8'hF3, 8'h83);
    pulse_done();
    check_reg("edge_stat_idle", 8'hF3, 8'h03);

    // Priority: sources 5 and 2 rise together, 2 is served first.
    applyStimulus(8'hF1, 8'hFF);
    applyStimulus(8'hF0, 8'hFF);
    src = 8'h24;
    tick();
    tick();
    src = 8'h00;
    tick();
    tick();
    checkOutput("prio_irq", 32'(irq), 32'h1);
    checkOutput("prio_first_id", 32'(irq_id), 32'h2);
    checkOutput("prio_first_vec", 32'(vector), 32'h3E4);
    pulse_ack();
    check_reg("prio_pend_after_ack", 8'hF2, 8'h20);
    pulse_done();
    checkOutput("prio_gap_irq", 32'(irq), 32'h0);
    tick();
    checkOutput("prio_second_irq", 32'(irq), 32'h1);
    checkOutput("prio_second_id", 32'(irq_id), 32'h5);
    checkOutput("prio_second_vec", 32'(vector), 32'h3EA);
    pulse_ack();
    pulse_done();
    check_reg("prio_pend_clear", 8'hF2, 8'h00);

    // Level source 0 asserts, then drops before ACK: request withdrawn.
    applyStimulus(8'hF1, 8'h00);
    applyStimulus(8'hF0, 8'h01);
    src = 8'h01;
    tick();
    tick();
    checkOutput("level_lat_e2", 32'(irq), 32'h0);
    tick();
    checkOutput("level_lat_e3", 32'(irq), 32'h1);
    checkOutput("level_id", 32'(irq_id), 32'h0);
    src = 8'h00;
    tick();
    tick();
    checkOutput("level_hold", 32'(irq), 32'h1);
    tick();
    checkOutput("level_withdraw_irq", 32'(irq), 32'h0);
    check_reg("level_withdraw_stat", 8'hF3, 8'h00);
    check_reg("level_no_pend", 8'hF2, 8'h00);

    // W1C on PEND[1] in the same cycle that a new rise is captured.
    applyStimulus(8'hF0, 8'h00);
    applyStimulus(8'hF1, 8'h02);
    src = 8'h02;
    tick();
    tick();
    src = 8'h00;
    tick();
    tick();
    check_reg("w1c_pend_set", 8'hF2, 8'h02);
    src = 8'h02;
    tick();
    tick();
    applyStimulus(8'hF2, 8'h02);
    src = 8'h00;
    check_reg("w1c_race_pend", 8'hF2, 8'h02);
    tick();
    tick();
    applyStimulus(8'hF2, 8'h02);
    check_reg("w1c_plain_clear", 8'hF2, 8'h00);

    // Masked capture on source 4, then unmask: IRQ two edges after the strobe.
    applyStimulus(8'hF1, 8'h10);
    src = 8'h10;
    tick();
    tick();
    src = 8'h00;
    tick();
    tick();
    check_reg("masked_pend", 8'hF2, 8'h10);
    checkOutput("masked_irq", 32'(irq), 32'h0);
    applyStimulus(8'hF0, 8'h10);
    checkOutput("unmask_e1", 32'(irq), 32'h0);
    tick();
    checkOutput("unmask_e2", 32'(irq), 32'h1);
    checkOutput("unmask_id", 32'(irq_id), 32'h4);
    checkOutput("unmask_vec", 32'(vector), 32'h3E8);

    // Asynchronous reset while in ASSERT.
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("async_rst_irq", 32'(irq), 32'h0);
    checkOutput("async_rst_vec", 32'(vector), 32'h3E0);
    checkOutput("async_rst_id", 32'(irq_id), 32'h0);
    check_reg("async_rst_mask", 8'hF0, 8'h00);
    check_reg("async_rst_mode", 8'hF1, 8'h00);
    check_reg("async_rst_pend", 8'hF2, 8'h00);
    check_reg("async_rst_stat", 8'hF3, 8'h00);
    tick();
    reset_n = 1'b1;
    tick();
    tick();
    checkOutput("post_rst_irq", 32'(irq), 32'h0);
    check_reg("post_rst_stat", 8'hF3, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
